seg7_hex_scan: RTL

Downstream display stage for the 8-bit up/down counter board design. It takes the 16-bit LED word (load switches on [15:8], count on [7:0]) and shows it as four hexadecimal digits on the board's common-anode, time-multiplexed seven-segment display. A refresh divider scans the digits. A frame latch keeps the displayed value from tearing while it changes. Optional leading-zero blanking and per-digit decimal points are included.

---
 rtl/seg7_hex_scan.sv | 125 ++++++++++++
 1 files changed

// File: rtl/seg7_hex_scan.sv
// ============================================================================
// Module      : seg7_hex_scan
// Description : Four-digit hex scanner for a common-anode, multiplexed
//               seven-segment display with frame latch and zero blanking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_hex_scan #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    input  logic        en,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_tick
);

    localparam int             DIV_W    = $clog2(REFRESH_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [6:0]     SEG_OFF  = 7'b1111111;

    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       idx_q, idx_d;
    logic [15:0]      value_q, value_d;
    logic [3:0]       dp_q, dp_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_pin_q, dp_pin_d;
    logic             tick_q, tick_d;

    logic             w_slot_end;
    logic             w_frame_end;
    logic [3:0]       w_nibble;
    logic [3:0]       w_nib_zero;
    logic [3:0]       w_lz_mask;
    logic [6:0]       w_glyph;

    assign w_slot_end  = (div_q == DIV_LAST);
    assign w_frame_end = w_slot_end && (idx_q == 2'd3);
    assign w_nibble    = value_q[{idx_q, 2'b00} +: 4];

    assign w_nib_zero[0] = (value_q[3:0]   == 4'h0);
    assign w_nib_zero[1] = (value_q[7:4]   == 4'h0);
    assign w_nib_zero[2] = (value_q[11:8]  == 4'h0);
    assign w_nib_zero[3] = (value_q[15:12] == 4'h0);

    // A digit is a leading zero only if it and every digit above it are zero;
    // digit 0 always shows so an all-zero word reads "0".
    assign w_lz_mask[3] = w_nib_zero[3];
    assign w_lz_mask[2] = w_nib_zero[3] & w_nib_zero[2];
    assign w_lz_mask[1] = w_nib_zero[3] & w_nib_zero[2] & w_nib_zero[1];
    assign w_lz_mask[0] = 1'b0;

    always_comb begin
        w_glyph = SEG_OFF;
        case (w_nibble)
            4'h0: w_glyph = 7'b1000000;
            4'h1: w_glyph = 7'b1111001;
            4'h2: w_glyph = 7'b0100100;
            4'h3: w_glyph = 7'b0110000;
            4'h4: w_glyph = 7'b0011001;
            4'h5: w_glyph = 7'b0010010;
            4'h6: w_glyph = 7'b0000010;
            4'h7: w_glyph = 7'b1111000;
            4'h8: w_glyph = 7'b0000000;
            4'h9: w_glyph = 7'b0010000;
            4'hA: w_glyph = 7'b0001000;
            4'hB: w_glyph = 7'b0000011;
            4'hC: w_glyph = 7'b1000110;
            4'hD: w_glyph = 7'b0100001;
            4'hE: w_glyph = 7'b0000110;
            4'hF: w_glyph = 7'b0001110;
            default: w_glyph = SEG_OFF;
        endcase
    end

    always_comb begin
        div_d   = w_slot_end ? '0 : div_q + 1'b1;
        idx_d   = w_slot_end ? idx_q + 2'd1 : idx_q;
        value_d = w_frame_end ? value : value_q;
        dp_d    = w_frame_end ? dp_in : dp_q;
        tick_d  = w_frame_end;

        // Outputs track the digit selected this cycle; en only gates the anodes.
        an_d     = en ? ~(4'b0001 << idx_q) : 4'b1111;
        seg_d    = (blank_lz && w_lz_mask[idx_q]) ? SEG_OFF : w_glyph;
        dp_pin_d = ~dp_q[idx_q];
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            div_q    <= '0;
            idx_q    <= 2'd0;
            value_q  <= 16'h0000;
            dp_q     <= 4'h0;
            an_q     <= 4'b1111;
            seg_q    <= SEG_OFF;
            dp_pin_q <= 1'b1;
            tick_q   <= 1'b0;
        end else begin
            div_q    <= div_d;
            idx_q    <= idx_d;
            value_q  <= value_d;
            dp_q     <= dp_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            dp_pin_q <= dp_pin_d;
            tick_q   <= tick_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_pin_q;
    assign frame_tick = tick_q;

endmodule

`default_nettype wire
